// File: rtl/run_ctrl.sv
// Run controller for a small pipelined core: launches a run on a start edge,
// drains the back end after a decoded halt and keeps cycle/retire counters.
module run_ctrl #(
    parameter int DRAIN_CYCLES = 3,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             halt_id,
    input  logic             wb_valid,
    output logic             pc_clr,
    output logic             fetch_en,
    output logic             pipe_en,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] retire_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_e;

    localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYCLES - 1);

    state_e           state_q, state_d;
    logic [3:0]       drain_q, drain_d;
    logic             start_q;
    logic [CNT_W-1:0] cycle_q, retire_q;
    logic             pc_clr_q, fetch_q, pipe_q, busy_q, done_q;
    logic             launch;
    logic             counting;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_W'(1);
    endfunction

    assign launch   = start & ~start_q;
    assign counting = (state_q == S_RUN) || (state_q == S_DRAIN);

    always_comb begin
        state_d = state_q;
        drain_d = drain_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (launch) state_d = S_LAUNCH;
            end
            S_LAUNCH: state_d = S_RUN;
            S_RUN: begin
                if (halt_id) begin
                    state_d = S_DRAIN;
                    drain_d = DRAIN_LOAD;
                end
            end
            S_DRAIN: begin
                if (drain_q == 4'd0) state_d = S_DONE;
                else                 drain_d = drain_q - 4'd1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are registered from the next state, so they always match the
    // state being entered and never see an input combinationally.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            drain_q  <= 4'd0;
            start_q  <= 1'b0;
            cycle_q  <= '0;
            retire_q <= '0;
            pc_clr_q <= 1'b0;
            fetch_q  <= 1'b0;
            pipe_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            drain_q  <= drain_d;
            start_q  <= start;
            pc_clr_q <= (state_d == S_LAUNCH);
            fetch_q  <= (state_d == S_RUN);
            pipe_q   <= (state_d == S_RUN) || (state_d == S_DRAIN);
            busy_q   <= (state_d == S_LAUNCH) || (state_d == S_RUN) || (state_d == S_DRAIN);
            done_q   <= (state_d == S_DONE);
            // Clearing on entry makes the counters read zero during LAUNCH.
            if (state_d == S_LAUNCH) begin
                cycle_q  <= '0;
                retire_q <= '0;
            end else if (counting) begin
                cycle_q <= sat_inc(cycle_q);
                if (wb_valid) retire_q <= sat_inc(retire_q);
            end
        end
    end

    assign pc_clr     = pc_clr_q;
    assign fetch_en   = fetch_q;
    assign pipe_en    = pipe_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign cycle_cnt  = cycle_q;
    assign retire_cnt = retire_q;

endmodule

// File: tb/tb_run_ctrl.sv
// Bench for run_ctrl: directed scenarios then random traffic, every cycle
// checked against a run-timeline model on a 32-bit and a 4-bit counter instance.
module tb_run_ctrl;

    localparam int DRAIN = 3;

    logic clk = 1'b0;
    logic rst, start, halt_id, wb_valid;

    logic        pc_a, fe_a, pe_a, bz_a, dn_a;
    logic [31:0] cc_a, rc_a;
    logic        pc_b, fe_b, pe_b, bz_b, dn_b;
    logic [3:0]  cc_b, rc_b;

    int n_tests = 0;
    int n_fail  = 0;
    int n_pc = 0, n_fe = 0, n_pe = 0;

    // Model: a run is described by its age (0 = launch cycle) and the age at
    // which halt was taken; outputs follow from where the age falls.
    bit     m_active, m_done, m_prev;
    int     m_age, m_halt;
    longint m_cyc, m_ret;

    always #5 clk = ~clk;

    run_ctrl #(.DRAIN_CYCLES(DRAIN), .CNT_W(32)) u_a (
        .clk(clk), .rst(rst), .start(start), .halt_id(halt_id), .wb_valid(wb_valid),
        .pc_clr(pc_a), .fetch_en(fe_a), .pipe_en(pe_a), .busy(bz_a), .done(dn_a),
        .cycle_cnt(cc_a), .retire_cnt(rc_a)
    );

    run_ctrl #(.DRAIN_CYCLES(DRAIN), .CNT_W(4)) u_b (
        .clk(clk), .rst(rst), .start(start), .halt_id(halt_id), .wb_valid(wb_valid),
        .pc_clr(pc_b), .fetch_en(fe_b), .pipe_en(pe_b), .busy(bz_b), .done(dn_b),
        .cycle_cnt(cc_b), .retire_cnt(rc_b)
    );

    function automatic longint satw(longint v, int w);
        longint mx;
        mx = (longint'(1) << w) - 1;
        return (v > mx) ? mx : v;
    endfunction

    task automatic chk(string tag, longint obs, longint exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_update();
        bit edge_s;
        edge_s = start && !m_prev;
        if (rst) begin
            m_active = 0; m_done = 0; m_prev = 0;
            m_cyc = 0; m_ret = 0; m_age = 0; m_halt = -1;
        end else begin
            m_prev = start;
            if (m_active) begin
                if (m_age >= 1) begin
                    m_cyc++;
                    if (wb_valid) m_ret++;
                    if (m_halt < 0 && halt_id) m_halt = m_age;
                end
                m_age++;
                if (m_halt >= 0 && m_age > m_halt + DRAIN) begin
                    m_active = 0;
                    m_done   = 1;
                end
            end else if (edge_s) begin
                m_active = 1; m_done = 0; m_age = 0; m_halt = -1;
                m_cyc = 0; m_ret = 0;
            end
        end
    endtask

    task automatic check_inst(string nm, logic pc, logic fe, logic pe, logic bz, logic dn,
                              longint cc, longint rc, int w);
        chk({nm, ".pc_clr"},   pc, m_active && m_age == 0);
        chk({nm, ".fetch_en"}, fe, m_active && m_age >= 1 && m_halt < 0);
        chk({nm, ".pipe_en"},  pe, m_active && m_age >= 1);
        chk({nm, ".busy"},     bz, m_active);
        chk({nm, ".done"},     dn, !m_active && m_done);
        chk({nm, ".cycle_cnt"},  cc, satw(m_cyc, w));
        chk({nm, ".retire_cnt"}, rc, satw(m_ret, w));
    endtask

    task automatic step(input logic s, input logic h, input logic w, input logic r);
        start = s; halt_id = h; wb_valid = w; rst = r;
        @(posedge clk);
        model_update();
        @(negedge clk);
        check_inst("A", pc_a, fe_a, pe_a, bz_a, dn_a, cc_a, rc_a, 32);
        check_inst("B", pc_b, fe_b, pe_b, bz_b, dn_b, cc_b, rc_b, 4);
        if (pc_a) n_pc++;
        if (fe_a) n_fe++;
        if (pe_a) n_pe++;
    endtask

    initial begin
        // Reset and idle
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 0);
        chk("idle.busy", bz_a, 0);
        chk("idle.cycle_cnt", cc_a, 0);

        // Basic run: 10 RUN cycles, halt on the last, 7 retirements
        n_pc = 0; n_fe = 0; n_pe = 0;
        step(1, 0, 0, 0);
        step(0, 1, 1, 0);
        for (int i = 0; i < 10; i++) step(0, i == 9, i < 7, 0);
        for (int i = 0; i < DRAIN; i++) step(0, 0, 0, 0);
        step(0, 1, 1, 0);
        step(0, 0, 1, 0);
        chk("run1.pc_pulses", n_pc, 1);
        chk("run1.fetch_cycles", n_fe, 10);
        chk("run1.pipe_cycles", n_pe, 13);
        chk("run1.done", dn_a, 1);
        chk("run1.cycle_cnt", cc_a, 13);
        chk("run1.retire_cnt", rc_a, 7);

        // Start held high through a run, with a fresh edge during DRAIN
        n_pc = 0;
        for (int i = 0; i < 20; i++) step(i != 8, i == 6, 1, 0);
        chk("hold.launches", n_pc, 1);
        chk("hold.done", dn_a, 1);
        chk("hold.cycle_cnt", cc_a, 8);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        chk("hold.no_relaunch", bz_a, 0);

        // Relaunch from DONE
        step(1, 0, 0, 0);
        chk("relaunch.done", dn_a, 0);
        chk("relaunch.cycle_cnt", cc_a, 0);
        chk("relaunch.retire_cnt", rc_a, 0);
        step(0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, i == 2, 1, 0);
        for (int i = 0; i < DRAIN; i++) step(0, 0, 0, 0);
        chk("relaunch.cycle_cnt_end", cc_a, 6);
        chk("relaunch.retire_cnt_end", rc_a, 3);

        // Reset in the middle of RUN
        step(0, 0, 0, 0);
        step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 1, 0);
        chk("midrst.cycle_cnt_pre", cc_a, 4);
        step(0, 0, 0, 1);
        chk("midrst.busy", bz_a, 0);
        chk("midrst.done", dn_a, 0);
        chk("midrst.cycle_cnt", cc_a, 0);
        chk("midrst.retire_cnt", rc_a, 0);

        // Long run: narrow counters must saturate
        step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        for (int i = 0; i < 20; i++) step(0, i == 19, 1, 0);
        for (int i = 0; i < DRAIN; i++) step(0, 0, 1, 0);
        chk("sat.narrow_cycle", cc_b, 15);
        chk("sat.narrow_retire", rc_b, 15);
        chk("sat.wide_cycle", cc_a, 23);

        // Start held across reset release launches immediately
        step(1, 0, 0, 1);
        step(1, 0, 0, 0);
        chk("rst_release.pc_clr", pc_a, 1);

        // Random traffic
        for (int i = 0; i < 3000; i++)
            step($urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0,
                 1'($urandom_range(0, 1)), $urandom_range(0, 199) == 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/run_ctrl.md
RUN_CTRL -- requirements
Module: run_ctrl

Interface
REQ-001 Parameter DRAIN_CYCLES, default 3: cycles the pipeline stays enabled after halt is decoded (EX, MEM, WB); legal range 1..15.
REQ-002 Parameter CNT_W, default 32: width of both performance counters.
REQ-003 Port clk  input  1: single clock; all state updates on the rising edge.
REQ-004 Port rst  input  1: synchronous, active-high reset.
REQ-005 Port start  input  1: launch request from the bench or host; level input, acted on at its rising edge only.
REQ-006 Port halt_id  input  1: a halt instruction is valid in the decode stage this cycle.
REQ-007 Port wb_valid  input  1: one instruction retires in writeback this cycle.
REQ-008 Port pc_clr  output  1: one-cycle pulse that clears the PC and the pipeline registers before a run.
REQ-009 Port fetch_en  output  1: the IF stage may fetch and advance the PC.
REQ-010 Port pipe_en  output  1: the ID/EX/MEM/WB pipeline registers may advance.
REQ-011 Port busy  output  1: a run is in progress (LAUNCH, RUN or DRAIN).
REQ-012 Port done  output  1: the last run completed; held until the next launch or reset.
REQ-013 Port cycle_cnt  output  CNT_W: count of enabled cycles in the current or last run.
REQ-014 Port retire_cnt  output  CNT_W: count of retired instructions in the current or last run.

Function
REQ-015 The block SHALL register start into start_d every cycle and SHALL treat start=1 && start_d=0 as a rising edge (launch edge).
REQ-016 The FSM SHALL have the states IDLE, LAUNCH, RUN, DRAIN and DONE.
REQ-017 IDLE and DONE: a launch edge SHALL move the FSM to LAUNCH on the next edge; otherwise the FSM SHALL hold its state.
REQ-018 LAUNCH SHALL last exactly one cycle and SHALL then move to RUN; during LAUNCH the block SHALL drive pc_clr=1 and fetch_en=pipe_en=0, and SHALL clear cycle_cnt and retire_cnt to 0.
REQ-019 RUN SHALL drive fetch_en=1 and pipe_en=1.
REQ-020 In RUN, halt_id=1 SHALL move the FSM to DRAIN on the next edge and SHALL load the drain counter with DRAIN_CYCLES-1.
REQ-021 DRAIN SHALL drive fetch_en=0 and pipe_en=1.
REQ-022 In DRAIN, the drain counter SHALL decrement every cycle, and the FSM SHALL move to DONE on the edge after the cycle in which the counter equals 0; DRAIN therefore lasts exactly DRAIN_CYCLES cycles.
REQ-023 DONE SHALL drive done=1 and fetch_en=pipe_en=0; done SHALL be 0 in every other state.
REQ-024 busy SHALL be 1 exactly in LAUNCH, RUN and DRAIN.
REQ-025 All control outputs (pc_clr, fetch_en, pipe_en, busy, done) SHALL be pure decodes of the current state, with zero combinational path from any input.
REQ-026 cycle_cnt SHALL increment by 1 on each cycle spent in RUN or DRAIN.
REQ-027 retire_cnt SHALL increment by 1 on each cycle with wb_valid=1 while in RUN or DRAIN; wb_valid in any other state SHALL be ignored.
REQ-028 Both counters SHALL saturate at all-ones without wrapping, and SHALL hold their values in IDLE and DONE.
REQ-029 Launch edges in LAUNCH, RUN or DRAIN SHALL be ignored and SHALL NOT be queued.
REQ-030 Holding start high for multiple cycles SHALL produce exactly one launch.
REQ-031 halt_id in any state other than RUN SHALL be ignored.
REQ-032 A halt_id that coincides with the last RUN cycle SHALL still be honoured per REQ-020.

Reset
REQ-033 With rst=1 at an edge, the FSM SHALL go to IDLE, start_d, the drain counter and both counters SHALL go to 0, and all outputs SHALL be 0 from the following cycle.
REQ-034 rst SHALL take priority over every other input, and a reset mid-run SHALL abort the run without asserting done.
REQ-035 Because start_d resets to 0, start held at 1 across reset release SHALL count as a launch edge in the first cycle after reset.

Verification
REQ-036 Reset, then hold start=0 for 5 cycles -> FSM stays in IDLE; all outputs 0; both counters 0.
REQ-037 Pulse start for 1 cycle; 10 cycles later assert halt_id for 1 cycle; assert wb_valid on 7 of those cycles -> pc_clr pulses once; fetch_en is high 10 cycles; pipe_en is high 13 cycles; done rises and holds; cycle_cnt=13; retire_cnt=7.
REQ-038 Hold start high for 20 cycles through a full run, and pulse start again during DRAIN -> exactly one launch occurs; no relaunch happens after DONE until start falls and rises again.
REQ-039 From DONE, issue a new launch edge -> done drops in LAUNCH; counters clear to 0 in LAUNCH; the second run counts independently.
REQ-040 Assert rst for 1 cycle during RUN at cycle_cnt=4 -> IDLE on the next cycle; busy=0; done=0; counters 0.
REQ-041 Set CNT_W=4 and run 20 cycles before halt -> cycle_cnt saturates at 15 and does not wrap.
